// File: rtl/srl_var_tap.sv
// Variable-tap shift register: DEPTH stages of WIDTH bits, a combinational read tap
// selected by a, plus fill tracking so consumers know which taps hold real data.
module srl_var_tap #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             e,
    input  logic [WIDTH-1:0] i,
    input  logic [AW-1:0]    a,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_last,
    output logic             vld,
    output logic             full,
    output logic [AW:0]      cnt
);

    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             a_in_range;

    // clr wins over e so a flush never admits a new word.
    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (clr) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_d[k] = '0;
            end
            cnt_d = '0;
        end else if (e) begin
            stage_d[0] = i;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (cnt_q != DepthCnt) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    // Addresses past the last stage (non-power-of-2 DEPTH) read as zero and invalid.
    always_comb begin
        q = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (a == AW'(k)) begin
                q = stage_q[k];
            end
        end
        a_in_range = ({1'b0, a} < DepthCnt);
        vld        = a_in_range && (cnt_q > {1'b0, a});
    end

    assign q_last = stage_q[DEPTH-1];
    assign full   = (cnt_q == DepthCnt);
    assign cnt    = cnt_q;

endmodule

// File: tb/tb_srl_var_tap.sv
// Directed bench for srl_var_tap: main instance at WIDTH=4/DEPTH=8, plus DEPTH=6 and
// WIDTH=1/DEPTH=2 instances for address-range and degenerate-width cases.
module tb_srl_var_tap;

    logic clk;
    logic rst_n;

    logic       clr8, e8;
    logic [3:0] i8, q8, ql8, cnt8;
    logic [2:0] a8;
    logic       vld8, full8;

    logic       clr6, e6;
    logic [3:0] i6, q6, ql6, cnt6;
    logic [2:0] a6;
    logic       vld6, full6;

    logic       clr2, e2;
    logic [0:0] i2, q2, ql2, a2;
    logic [1:0] cnt2;
    logic       vld2, full2;

    int checks;
    int failures;

    srl_var_tap #(.WIDTH(4), .DEPTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .clr(clr8), .e(e8), .i(i8), .a(a8),
        .q(q8), .q_last(ql8), .vld(vld8), .full(full8), .cnt(cnt8)
    );

    srl_var_tap #(.WIDTH(4), .DEPTH(6)) u6 (
        .clk(clk), .rst_n(rst_n), .clr(clr6), .e(e6), .i(i6), .a(a6),
        .q(q6), .q_last(ql6), .vld(vld6), .full(full6), .cnt(cnt6)
    );

    srl_var_tap #(.WIDTH(1), .DEPTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr2), .e(e2), .i(i2), .a(a2),
        .q(q2), .q_last(ql2), .vld(vld2), .full(full2), .cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift8(input logic [3:0] v);
        e8 = 1'b1;
        i8 = v;
        step();
        e8 = 1'b0;
    endtask

    task automatic flush8();
        clr8 = 1'b1;
        step();
        clr8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        a8 = 3'd0;
        #1;
        checks++; if (q8 !== 4'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q8); end
        checks++; if (ql8 !== 4'd0) begin failures++; $display("FAIL reset_q_last got=%0d exp=0", ql8); end
        checks++; if (vld8 !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b exp=0", vld8); end
        checks++; if (full8 !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full8); end
        checks++; if (cnt8 !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt8); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (cnt8 !== 4'd0) begin failures++; $display("FAIL post_reset_no_shift got=%0d exp=0", cnt8); end
    endtask

    task automatic test_fill();
        e8 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            i8 = 4'(k);
            step();
        end
        e8 = 1'b0;
        checks++; if (cnt8 !== 4'd8) begin failures++; $display("FAIL fill_cnt got=%0d exp=8", cnt8); end
        checks++; if (full8 !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b exp=1", full8); end
        checks++; if (ql8 !== 4'd1) begin failures++; $display("FAIL fill_q_last got=%0d exp=1", ql8); end
        for (int k = 0; k < 8; k++) begin
            a8 = 3'(k);
            #1;
            checks++;
            if (q8 !== 4'(8 - k)) begin
                failures++; $display("FAIL fill_q a=%0d got=%0d exp=%0d", k, q8, 8 - k);
            end
            checks++;
            if (vld8 !== 1'b1) begin
                failures++; $display("FAIL fill_vld a=%0d got=%0b exp=1", k, vld8);
            end
        end
    endtask

    task automatic test_enable_gap();
        flush8();
        checks++; if (cnt8 !== 4'd0) begin failures++; $display("FAIL gap_clr_cnt got=%0d exp=0", cnt8); end
        shift8(4'd5);
        shift8(4'd6);
        shift8(4'd7);
        i8 = 4'd15;
        repeat (4) step();
        checks++; if (cnt8 !== 4'd3) begin failures++; $display("FAIL gap_cnt got=%0d exp=3", cnt8); end
        a8 = 3'd0; #1;
        checks++; if (q8 !== 4'd7) begin failures++; $display("FAIL gap_q0 got=%0d exp=7", q8); end
        a8 = 3'd2; #1;
        checks++; if (q8 !== 4'd5) begin failures++; $display("FAIL gap_q2 got=%0d exp=5", q8); end
        checks++; if (vld8 !== 1'b1) begin failures++; $display("FAIL gap_vld2 got=%0b exp=1", vld8); end
        a8 = 3'd3; #1;
        checks++; if (vld8 !== 1'b0) begin failures++; $display("FAIL gap_vld3 got=%0b exp=0", vld8); end
        checks++; if (full8 !== 1'b0) begin failures++; $display("FAIL gap_full got=%0b exp=0", full8); end
    endtask

    task automatic test_sat_flush();
        flush8();
        e8 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            i8 = 4'(k);
            step();
        end
        e8 = 1'b0;
        checks++; if (cnt8 !== 4'd8) begin failures++; $display("FAIL sat_cnt got=%0d exp=8", cnt8); end
        checks++; if (ql8 !== 4'd5) begin failures++; $display("FAIL sat_q_last got=%0d exp=5", ql8); end
        a8 = 3'd0; #1;
        checks++; if (q8 !== 4'd12) begin failures++; $display("FAIL sat_q0 got=%0d exp=12", q8); end
        clr8 = 1'b1;
        e8   = 1'b1;
        i8   = 4'd9;
        step();
        clr8 = 1'b0;
        e8   = 1'b0;
        checks++; if (cnt8 !== 4'd0) begin failures++; $display("FAIL flush_cnt got=%0d exp=0", cnt8); end
        checks++; if (full8 !== 1'b0) begin failures++; $display("FAIL flush_full got=%0b exp=0", full8); end
        checks++; if (ql8 !== 4'd0) begin failures++; $display("FAIL flush_q_last got=%0d exp=0", ql8); end
        for (int k = 0; k < 8; k++) begin
            a8 = 3'(k);
            #1;
            checks++;
            if (q8 !== 4'd0 || vld8 !== 1'b0) begin
                failures++;
                $display("FAIL flush_tap a=%0d got q=%0d vld=%0b exp q=0 vld=0", k, q8, vld8);
            end
        end
    endtask

    task automatic test_async_reset();
        flush8();
        for (int k = 1; k <= 5; k++) shift8(4'(k + 2));
        a8 = 3'd0; #1;
        checks++; if (cnt8 !== 4'd5) begin failures++; $display("FAIL async_pre_cnt got=%0d exp=5", cnt8); end
        checks++; if (q8 !== 4'd7) begin failures++; $display("FAIL async_pre_q got=%0d exp=7", q8); end
        rst_n = 1'b0;
        #1;
        checks++; if (cnt8 !== 4'd0) begin failures++; $display("FAIL async_cnt got=%0d exp=0", cnt8); end
        checks++; if (q8 !== 4'd0) begin failures++; $display("FAIL async_q got=%0d exp=0", q8); end
        #1;
        rst_n = 1'b1;
        step();
        checks++; if (cnt8 !== 4'd0) begin failures++; $display("FAIL async_idle_cnt got=%0d exp=0", cnt8); end
        shift8(4'd3);
        checks++; if (cnt8 !== 4'd1) begin failures++; $display("FAIL async_first_cnt got=%0d exp=1", cnt8); end
        checks++; if (q8 !== 4'd3) begin failures++; $display("FAIL async_first_q got=%0d exp=3", q8); end
        a8 = 3'd1; #1;
        checks++; if (vld8 !== 1'b0) begin failures++; $display("FAIL async_vld1 got=%0b exp=0", vld8); end
    endtask

    task automatic test_out_of_range();
        clr6 = 1'b1; step(); clr6 = 1'b0;
        e6 = 1'b1;
        for (int k = 10; k <= 15; k++) begin
            i6 = 4'(k);
            step();
        end
        e6 = 1'b0;
        checks++; if (full6 !== 1'b1) begin failures++; $display("FAIL oor_full got=%0b exp=1", full6); end
        checks++; if (cnt6 !== 4'd6) begin failures++; $display("FAIL oor_cnt got=%0d exp=6", cnt6); end
        a6 = 3'd6; #1;
        checks++; if (q6 !== 4'd0) begin failures++; $display("FAIL oor_q6 got=%0d exp=0", q6); end
        checks++; if (vld6 !== 1'b0) begin failures++; $display("FAIL oor_vld6 got=%0b exp=0", vld6); end
        a6 = 3'd7; #1;
        checks++; if (q6 !== 4'd0) begin failures++; $display("FAIL oor_q7 got=%0d exp=0", q6); end
        checks++; if (vld6 !== 1'b0) begin failures++; $display("FAIL oor_vld7 got=%0b exp=0", vld6); end
        a6 = 3'd5; #1;
        checks++; if (q6 !== 4'd10) begin failures++; $display("FAIL oor_q5 got=%0d exp=10", q6); end
        checks++; if (ql6 !== 4'd10) begin failures++; $display("FAIL oor_q_last got=%0d exp=10", ql6); end
        checks++; if (vld6 !== 1'b1) begin failures++; $display("FAIL oor_vld5 got=%0b exp=1", vld6); end
    endtask

    task automatic test_width1();
        clr2 = 1'b1; step(); clr2 = 1'b0;
        e2 = 1'b1;
        i2 = 1'b1; step();
        i2 = 1'b0; step();
        e2 = 1'b0;
        a2 = 1'b0; #1;
        checks++; if (q2 !== 1'b0) begin failures++; $display("FAIL w1_q0 got=%0b exp=0", q2); end
        checks++; if (ql2 !== 1'b1) begin failures++; $display("FAIL w1_q_last got=%0b exp=1", ql2); end
        checks++; if (full2 !== 1'b1) begin failures++; $display("FAIL w1_full got=%0b exp=1", full2); end
        checks++; if (cnt2 !== 2'd2) begin failures++; $display("FAIL w1_cnt got=%0d exp=2", cnt2); end
        a2 = 1'b1; #1;
        checks++; if (q2 !== 1'b1) begin failures++; $display("FAIL w1_q1 got=%0b exp=1", q2); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b1;
        clr8 = 1'b0; e8 = 1'b0; i8 = '0; a8 = '0;
        clr6 = 1'b0; e6 = 1'b0; i6 = '0; a6 = '0;
        clr2 = 1'b0; e2 = 1'b0; i2 = '0; a2 = '0;
        test_reset();
        test_fill();
        test_enable_gap();
        test_sat_flush();
        test_async_reset();
        test_out_of_range();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/srl_var_tap.md
SRL_VAR_TAP -- requirements
Module: srl_var_tap

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data bits per stage (legal range 1..64).
REQ-002 SHALL have parameter DEPTH, default 8, number of stages (legal range 2..256).
REQ-003 SHALL derive localparam AW = max(1, clog2(DEPTH)) as the tap-address width, not overridable.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr  input  1  synchronous flush of data and fill count.
REQ-007 SHALL have port e  input  1  shift enable.
REQ-008 SHALL have port i  input  WIDTH  serial data in.
REQ-009 SHALL have port a  input  AW  dynamic tap address; a=0 selects stage 1, the newest entry.
REQ-010 SHALL have port q  output  WIDTH  data at tap a.
REQ-011 SHALL have port q_last  output  WIDTH  data at stage DEPTH.
REQ-012 SHALL have port vld  output  1  tap a holds data shifted in since the last reset or clr.
REQ-013 SHALL have port full  output  1  all DEPTH stages hold valid data.
REQ-014 SHALL have port cnt  output  AW+1  fill count, 0..DEPTH.

Function
REQ-015 SHALL shift on a rising clk edge with e=1 and clr=0: stage1<=i and stage k<=stage k-1 for k=2..DEPTH.
REQ-016 SHALL hold all stages and cnt unchanged on a rising edge with e=0 and clr=0.
REQ-017 SHALL, on a rising edge with clr=1, clear all stages to 0 and cnt to 0, regardless of e (clr has priority over e).
REQ-018 SHALL increment cnt by 1 on each shift while cnt<DEPTH, and saturate at DEPTH (no wrap).
REQ-019 SHALL drive q combinationally from a: q = stage a+1 for a<DEPTH; q=0 for a>=DEPTH (non-power-of-2 DEPTH).
REQ-020 SHALL drive vld combinationally: vld = (a<DEPTH) && (cnt>a).
REQ-021 SHALL drive full = (cnt==DEPTH), and q_last = stage DEPTH.
REQ-022 SHALL give tap a, after a value is shifted in, a read latency of exactly a further enabled shifts; q_last therefore lags i by DEPTH enabled shifts.
REQ-023 SHALL have outputs q and vld follow a change of a within the same cycle, with no clock dependency.
REQ-024 SHALL insert no bubbles: shifts on consecutive cycles with e held high are all accepted.

Reset
REQ-025 SHALL, while rst_n=0, force all stages to 0 and cnt to 0 immediately, without waiting for clk.
REQ-026 SHALL have the following output values in reset: q=0, q_last=0, vld=0, full=0, cnt=0.
REQ-027 SHALL, after release of rst_n, perform no shift until the first rising edge with e=1.
REQ-028 SHALL, when reset is asserted mid-fill, discard all data, so that the next shift yields cnt=1.

Verification (WIDTH=4, DEPTH=8 unless stated)
REQ-029 SHALL be covered by a fill test: shift i=1..8 with e=1 on consecutive cycles -> cnt=8, full=1, q_last=1, a=0 gives q=8, a=7 gives q=1, vld=1 for all a.
REQ-030 SHALL be covered by an enable-gap test: shift 3 values (i=5, 6, 7), then e=0 for 4 cycles -> cnt=3, a=0 gives q=7, a=2 gives q=5, a=3 gives vld=0.
REQ-031 SHALL be covered by a saturation and flush test: 12 shifts of i=1..12 -> cnt=8, q_last=5; then clr=1 with e=1 -> all stages 0, cnt=0, full=0.
REQ-032 SHALL be covered by an async reset test: assert rst_n=0 between clock edges after 5 shifts -> cnt=0 and q=0 before the next edge; the first shift after release gives cnt=1.
REQ-033 SHALL be covered by an out-of-range address test at DEPTH=6, AW=3: fill 6 values, set a=6 and a=7 -> q=0, vld=0; a=5 gives q = the first value shifted in.
REQ-034 SHALL be covered by a degenerate-width test at WIDTH=1, DEPTH=2: shift 1, then 0 -> a=0 gives q=0, q_last=1, full=1.
